dpram_be: RTL and testbench
===========================

# dpram_be

Single-clock true dual-port RAM with per-byte write enables, selectable same-port read-during-write behaviour, optional output register, deterministic cross-port write collision resolution and a built-in clear sequencer that fills the array with a constant after reset or on request. It is the generalised successor to the plain dual-port RAM used for shared work RAM and vector/video buffers between CPU and video-side logic. It removes the need for external init logic and byte-lane muxing at each instance.

## Interface
- ADDR_WIDTH, 15, address bits; depth = 2^ADDR_WIDTH words
- DATA_WIDTH, 8, word width; must be an integer multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, lane width; NB = DATA_WIDTH/BYTE_WIDTH lanes
- RDW_MODE, 0, same-port read-during-write: 0 = new data (write-first), 1 = old data (read-first)
- OUT_REG, 0, 1 adds a pipeline register on q_a/q_b
- CLEAR_VALUE, 0, DATA_WIDTH-bit word written by the clear sequencer

- clock  in  1  sole clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- clear  in  1  pulse in IDLE starts a clear sweep
- busy  out  1  high while clear sweep in progress
- collision  out  1  one-cycle pulse: both ports wrote the same address
- address_a / address_b  in  ADDR_WIDTH  port address
- data_a / data_b  in  DATA_WIDTH  write data
- wren_a / wren_b  in  1  write request
- byteena_a / byteena_b  in  NB  lane enables, bit i = bits [i*BYTE_WIDTH +: BYTE_WIDTH]
- rden_a / rden_b  in  1  read enable; low holds q
- q_a / q_b  out  DATA_WIDTH  read data

## Operation
- Clear FSM states: CLEAR, IDLE. Async reset → CLEAR, counter 0, busy 1.
- CLEAR: each cycle writes CLEAR_VALUE to mem[counter], counter+1; at counter = 2^ADDR_WIDTH-1 the write completes and the FSM enters IDLE next cycle. Sweep = 2^ADDR_WIDTH cycles. clear ignored while in CLEAR.
- IDLE: clear=1 → CLEAR with counter 0.
- While busy: all user writes dropped, reads not performed, q_a/q_b forced 0, collision 0.
- Write: when wren_x, lanes with byteena_x[i]=1 take data_x lane; other lanes keep old contents. wren_x with byteena_x = 0 writes nothing.
- Same-port read: performed when rden_x or wren_x. RDW_MODE 0: q = merged word (new enabled lanes, old others). RDW_MODE 1: q = pre-write word.
- Cross-port read of an address the other port writes in the same cycle always returns old data.
- Collision (both wren, addresses equal, IDLE): per lane, port A wins where byteena_a[i]=1; lanes only enabled on B take data_b; collision pulses the following cycle regardless of lane overlap.
- rden_x=0 and wren_x=0: q_x holds.
- Memory contents are not touched by reset itself; only the sweep initialises them.

## Timing
- Reset values: q_a = q_b = 0, busy = 1, collision = 0, output-stage registers 0.
- Read latency: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) from address/enable sample edge to q.
- Write visible to a read on either port issued the next cycle.
- busy falls exactly 2^ADDR_WIDTH cycles after the first clock edge following reset deassertion or after the edge sampling clear; first user access accepted on the edge where busy is already 0.
- Reset asserted mid-sweep: sweep restarts from address 0 after release.
- collision: registered, high for exactly one cycle per colliding cycle.

## Test plan
- ADDR_WIDTH=4, DATA_WIDTH=16, CLEAR_VALUE=16'hA5A5: release reset → busy high 16 cycles; then read all 16 addresses on both ports → 16'hA5A5 each.
- Byte write: A writes 16'h1234 to addr 3 with byteena 2'b01 over 16'hA5A5 → read 16'hA534; read-back on B next cycle same.
- RDW: write 16'hBEEF to addr 5 (holding 16'h0000) with rden; RDW_MODE=0 → q_a=16'hBEEF, RDW_MODE=1 → q_a=16'h0000; B reading addr 5 same cycle → 16'h0000.
- Collision: A writes 16'h1111 byteena 2'b01, B writes 16'h2222 byteena 2'b11, both addr 7 → mem[7]=16'h2211, collision one-cycle pulse next cycle.
- OUT_REG=1: read addr 3 → data appears 2 edges later; rden low afterwards → q holds.
- clear pulse in IDLE after writes → busy 16 cycles, q forced 0, writes during busy dropped, all words CLEAR_VALUE; reset at sweep cycle 8 → sweep restarts, 16 more cycles.

Source files
------------

// File: rtl/dpram_be.sv
// True dual-port RAM with per-byte write enables and a built-in clear sweep.
// Port A wins overlapping lanes when both ports write the same word.
module dpram_be #(
  parameter int unsigned              ADDR_WIDTH  = 15,
  parameter int unsigned              DATA_WIDTH  = 8,
  parameter int unsigned              BYTE_WIDTH  = 8,
  parameter int unsigned              RDW_MODE    = 0,
  parameter int unsigned              OUT_REG     = 0,
  parameter logic [DATA_WIDTH-1:0]    CLEAR_VALUE = '0
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 clear,
  output logic                                 busy,
  output logic                                 collision,
  input  logic [ADDR_WIDTH-1:0]                address_a,
  input  logic [ADDR_WIDTH-1:0]                address_b,
  input  logic [DATA_WIDTH-1:0]                data_a,
  input  logic [DATA_WIDTH-1:0]                data_b,
  input  logic                                 wren_a,
  input  logic                                 wren_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     byteena_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     byteena_b,
  input  logic                                 rden_a,
  input  logic                                 rden_b,
  output logic [DATA_WIDTH-1:0]                q_a,
  output logic [DATA_WIDTH-1:0]                q_b
);

  localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_e;

  state_e                  r_state, w_state_next;
  logic [ADDR_WIDTH-1:0]   r_cnt, w_cnt_next;
  logic                    w_busy;
  logic                    w_hit;
  logic [DATA_WIDTH-1:0]   w_old_a, w_old_b;
  logic [DATA_WIDTH-1:0]   w_mrg_a, w_mrg_b, w_wr_a;
  logic [DATA_WIDTH-1:0]   r_q_a, r_q_b;
  logic                    r_coll;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  // Clear sequencer state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_CLEAR: begin
        w_cnt_next = ADDR_WIDTH'(r_cnt + 1'b1);
        if (&r_cnt) w_state_next = S_IDLE;
      end
      S_IDLE: begin
        if (clear) begin
          w_state_next = S_CLEAR;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = S_CLEAR;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign w_busy = (r_state == S_CLEAR);
  assign busy   = w_busy;

  // Lane merges; a colliding A write folds in B's lanes under A's
  always_comb begin
    w_old_a = r_mem[address_a];
    w_old_b = r_mem[address_b];
    w_hit   = wren_a & wren_b & (address_a == address_b);
    w_mrg_a = w_old_a;
    w_mrg_b = w_old_b;
    for (int unsigned i = 0; i < NB; i++) begin
      if (byteena_a[i]) w_mrg_a[i*BYTE_WIDTH +: BYTE_WIDTH] = data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (byteena_b[i]) w_mrg_b[i*BYTE_WIDTH +: BYTE_WIDTH] = data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    w_wr_a = w_hit ? w_mrg_b : w_old_a;
    for (int unsigned i = 0; i < NB; i++) begin
      if (byteena_a[i]) w_wr_a[i*BYTE_WIDTH +: BYTE_WIDTH] = data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Array: reset never writes it, only the sweep initialises it
  always_ff @(posedge clock) begin
    if (w_busy) begin
      if (!reset) r_mem[r_cnt] <= CLEAR_VALUE;
    end else begin
      if (wren_b && (|byteena_b)) r_mem[address_b] <= w_mrg_b;
      if (wren_a && ((|byteena_a) || w_hit)) r_mem[address_a] <= w_wr_a;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q_a  <= '0;
      r_q_b  <= '0;
      r_coll <= 1'b0;
    end else begin
      r_coll <= ~w_busy & w_hit;
      if (w_busy) begin
        r_q_a <= '0;
        r_q_b <= '0;
      end else begin
        if (rden_a || wren_a) r_q_a <= (RDW_MODE == 0 && wren_a) ? w_mrg_a : w_old_a;
        if (rden_b || wren_b) r_q_b <= (RDW_MODE == 0 && wren_b) ? w_mrg_b : w_old_b;
      end
    end
  end

  assign collision = r_coll;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] r_q2_a, r_q2_b;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_q2_a <= '0;
          r_q2_b <= '0;
        end else if (w_busy) begin
          r_q2_a <= '0;
          r_q2_b <= '0;
        end else begin
          r_q2_a <= r_q_a;
          r_q2_b <= r_q_b;
        end
      end
      assign q_a = r_q2_a;
      assign q_b = r_q2_b;
    end else begin : g_noreg
      assign q_a = r_q_a;
      assign q_b = r_q_b;
    end
  endgenerate

endmodule

// File: tb/tb_dpram_be.sv
// Bench for dpram_be: two instances (write-first/unregistered, read-first/registered)
// share one stimulus stream and are checked by a scoreboard against an array model.
module tb_dpram_be;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned NB = 2;
  localparam logic [DW-1:0] CLR = 16'hA5A5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic [AW-1:0] address_a = '0, address_b = '0;
  logic [DW-1:0] data_a = '0, data_b = '0;
  logic          wren_a = 1'b0, wren_b = 1'b0, rden_a = 1'b0, rden_b = 1'b0;
  logic [NB-1:0] byteena_a = '0, byteena_b = '0;

  logic          busy0, busy1, coll0, coll1;
  logic [DW-1:0] q0_a, q0_b, q1_a, q1_b;

  always #5 clock = ~clock;

  dpram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .RDW_MODE(0),
             .OUT_REG(0), .CLEAR_VALUE(CLR)) u_dut0 (
    .clock(clock), .reset(reset), .clear(clear), .busy(busy0), .collision(coll0),
    .address_a(address_a), .address_b(address_b), .data_a(data_a), .data_b(data_b),
    .wren_a(wren_a), .wren_b(wren_b), .byteena_a(byteena_a), .byteena_b(byteena_b),
    .rden_a(rden_a), .rden_b(rden_b), .q_a(q0_a), .q_b(q0_b));

  dpram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .RDW_MODE(1),
             .OUT_REG(1), .CLEAR_VALUE(CLR)) u_dut1 (
    .clock(clock), .reset(reset), .clear(clear), .busy(busy1), .collision(coll1),
    .address_a(address_a), .address_b(address_b), .data_a(data_a), .data_b(data_b),
    .wren_a(wren_a), .wren_b(wren_b), .byteena_a(byteena_a), .byteena_b(byteena_b),
    .rden_a(rden_a), .rden_b(rden_b), .q_a(q1_a), .q_b(q1_b));

  typedef struct {
    int            due;
    int            inst;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
    logic          busy;
    logic          coll;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  logic [DW-1:0] mem_m [16];
  logic          busy_m = 1'b1;
  int            cnt_m = 0;
  logic [DW-1:0] s0a = '0, s0b = '0, s1a = '0, s1b = '0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] din,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < int'(NB); i++)
      if (be[i]) r[i*8 +: 8] = din[i*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input int inst, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc%0d: got %h want %h", name, inst, cyc, act, exp);
    end
  endtask

  // Monitor: compare every due expectation on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        if (e.inst == 0) begin
          chk("q_a", 0, q0_a, e.qa);
          chk("q_b", 0, q0_b, e.qb);
          chk("busy", 0, DW'(busy0), DW'(e.busy));
          chk("collision", 0, DW'(coll0), DW'(e.coll));
        end else begin
          chk("q_a", 1, q1_a, e.qa);
          chk("q_b", 1, q1_b, e.qb);
          chk("busy", 1, DW'(busy1), DW'(e.busy));
          chk("collision", 1, DW'(coll1), DW'(e.coll));
        end
      end
    end
  end

  // Advance model by one clock edge using current inputs, queue expectations, then clock
  task automatic step();
    logic [DW-1:0] oa, ob, n0a, n0b, n1a, n1b, n2a, n2b;
    logic ec;
    if (reset) begin
      busy_m = 1'b1; cnt_m = 0; ec = 1'b0;
      n0a = '0; n0b = '0; n1a = '0; n1b = '0; n2a = '0; n2b = '0;
    end else begin
      oa = mem_m[address_a];
      ob = mem_m[address_b];
      n0a = s0a; n0b = s0b; n1a = s1a; n1b = s1b;
      n2a = busy_m ? '0 : s1a;
      n2b = busy_m ? '0 : s1b;
      ec = !busy_m && wren_a && wren_b && (address_a == address_b);
      if (busy_m) begin
        n0a = '0; n0b = '0; n1a = '0; n1b = '0;
        mem_m[cnt_m] = CLR;
        cnt_m++;
        if (cnt_m == 16) busy_m = 1'b0;
      end else begin
        if (rden_a || wren_a) begin n0a = wren_a ? merge(oa, data_a, byteena_a) : oa; n1a = oa; end
        if (rden_b || wren_b) begin n0b = wren_b ? merge(ob, data_b, byteena_b) : ob; n1b = ob; end
        // A applied last so it owns any lane both ports enable
        if (wren_b) mem_m[address_b] = merge(mem_m[address_b], data_b, byteena_b);
        if (wren_a) mem_m[address_a] = merge(mem_m[address_a], data_a, byteena_a);
        if (clear) begin busy_m = 1'b1; cnt_m = 0; end
      end
    end
    s0a = n0a; s0b = n0b; s1a = n1a; s1b = n1b;
    sbq.push_back('{cyc + 1, 0, n0a, n0b, busy_m, ec});
    sbq.push_back('{cyc + 1, 1, n2a, n2b, busy_m, ec});
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic drive(input logic r, input logic c,
                       input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic [NB-1:0] bea, input logic ra,
                       input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                       input logic [NB-1:0] beb, input logic rb);
    reset = r; clear = c;
    wren_a = wa; address_a = aa; data_a = da; byteena_a = bea; rden_a = ra;
    wren_b = wb; address_b = ab; data_b = db; byteena_b = beb; rden_b = rb;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
  endtask

  task automatic rand_cycle(input logic allow_clear);
    logic [AW-1:0] aa, ab;
    aa = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 15));
    ab = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 15));
    drive(0, allow_clear && ($urandom_range(0, 79) == 0),
          $urandom_range(0, 2) == 0, aa, DW'($urandom), NB'($urandom_range(0, 3)),
          $urandom_range(0, 1) != 0,
          $urandom_range(0, 2) == 0, ab, DW'($urandom), NB'($urandom_range(0, 3)),
          $urandom_range(0, 1) != 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem_m[i] = 'x;
    drive(1, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
    drive(1, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
    idle(18);
    for (int i = 0; i < 16; i++)
      drive(0, 0, 0, AW'(i), '0, '0, 1, 0, AW'(15 - i), '0, '0, 1);
    // byte-lane write, then read back on both ports
    drive(0, 0, 1, 4'd3, 16'h1234, 2'b01, 1, 0, '0, '0, '0, 0);
    drive(0, 0, 0, 4'd3, '0, '0, 1, 0, 4'd3, '0, '0, 1);
    // read-during-write on A with cross-port read on B
    drive(0, 0, 1, 4'd5, 16'h0000, 2'b11, 0, 0, '0, '0, '0, 0);
    drive(0, 0, 1, 4'd5, 16'hBEEF, 2'b11, 1, 0, 4'd5, '0, '0, 1);
    drive(0, 0, 0, 4'd5, '0, '0, 1, 0, '0, '0, '0, 0);
    // same-address collision, then read it back
    drive(0, 0, 1, 4'd7, 16'h1111, 2'b01, 0, 1, 4'd7, 16'h2222, 2'b11, 0);
    drive(0, 0, 0, 4'd7, '0, '0, 1, 0, 4'd7, '0, '0, 1);
    drive(0, 0, 1, 4'd7, 16'hFFFF, 2'b00, 1, 0, '0, '0, '0, 0);
    drive(0, 0, 0, 4'd3, '0, '0, 1, 0, '0, '0, '0, 0);
    idle(4);
    for (int i = 0; i < 300; i++) rand_cycle(1'b1);
    idle(20);
    // clear request mid-traffic, writes during sweep, reset part way through
    drive(0, 0, 1, 4'd2, 16'h7777, 2'b11, 0, 0, '0, '0, '0, 0);
    drive(0, 1, 1, 4'd9, 16'h5555, 2'b11, 1, 0, 4'd2, '0, '0, 1);
    for (int i = 0; i < 7; i++) rand_cycle(1'b0);
    drive(1, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
    for (int i = 0; i < 18; i++) rand_cycle(1'b0);
    for (int i = 0; i < 16; i++)
      drive(0, 0, 0, AW'(i), '0, '0, 1, 0, AW'(i), '0, '0, 1);
    idle(3);
    @(negedge clock);
    #1;
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
